// File: rtl/neuron_mac.sv
// neuron_mac: serial saturating multiply-accumulate feeding the activation stage.
// Ports: clk, rst (async high), start, in_valid/x_in/w_in -> in_ready,
//        counter (accepted pairs), mult_sum_out (accumulator), sum_valid.
module neuron_mac #(
  parameter int BITS        = 8,
  parameter int W_BITS      = 15,
  parameter int COUNTER_END = 784
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic signed [BITS:0]   x_in,
  input  logic signed [W_BITS:0] w_in,
  output logic                   in_ready,
  output logic [31:0]            counter,
  output logic signed [BITS+24:0] mult_sum_out,
  output logic                   sum_valid
);

  localparam int ACC_W = BITS + 25;
  localparam int P_W   = BITS + W_BITS + 2;
  localparam logic [31:0] CNT_END = 32'(COUNTER_END);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [31:0]             r_cnt;
  logic [31:0]             w_cnt_nxt;
  logic [31:0]             w_cnt_inc;

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W-1:0] w_sat;

  assign w_prod     = x_in * w_in;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = $signed({r_acc[ACC_W-1], r_acc})
                    + $signed({w_prod_ext[ACC_W-1], w_prod_ext});
  assign w_cnt_inc  = r_cnt + 32'd1;

  // Top two bits of the widened sum disagree only on overflow.
  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    unique case (1'b1)
      (w_sum[ACC_W:ACC_W-1] == 2'b01):
        w_sat = {1'b0, {(ACC_W-1){1'b1}}};
      (w_sum[ACC_W:ACC_W-1] == 2'b10):
        w_sat = {1'b1, {(ACC_W-1){1'b0}}};
      default: w_sat = w_sum[ACC_W-1:0];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          w_acc_nxt = w_sat;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_END)
            w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign in_ready     = (r_state == S_ACCUM);
  assign sum_valid    = (r_state == S_DONE);
  assign counter      = r_cnt;
  assign mult_sum_out = r_acc;

endmodule
